// File: rtl/word_demux_1to2_pkg.sv
// Shared constants and encodings for the registered 1-to-2 word demultiplexer.
package word_demux_1to2_pkg;

  localparam int unsigned WIDTH_DEF     = 32;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/word_demux_1to2_demux_slot.sv
// One output slot: single-entry holding register, EMPTY/FULL state and delivered-word counter.
module demux_slot
  import word_demux_1to2_pkg::*;
#(
  parameter int unsigned Width    = WIDTH_DEF,
  parameter int unsigned CntWidth = CNT_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [Width-1:0]    load_data_i,
  input  logic                ready_i,
  output logic                free_o,
  output logic                valid_o,
  output logic [Width-1:0]    data_o,
  output logic [CntWidth-1:0] count_o
);

  slot_state_e         state_q;
  logic [Width-1:0]    data_q;
  logic [CntWidth-1:0] count_q;
  logic                drain;

  assign drain   = (state_q == FULL) && ready_i;
  assign free_o  = (state_q == EMPTY) || ready_i;
  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      // A load wins over a drain so a back-to-back stream keeps the slot FULL.
      if (load_i) begin
        state_q <= FULL;
        data_q  <= load_data_i;
      end else if (drain) begin
        state_q <= EMPTY;
      end
      if (drain) begin
        count_q <= count_q + CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/word_demux_1to2.sv
// Registered 1-to-2 word demultiplexer: steers each input word to slot A or B by in_sel.
module word_demux_1to2
  import word_demux_1to2_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [WIDTH-1:0]     out_a_data,
  output logic                 out_b_valid,
  input  logic                 out_b_ready,
  output logic [WIDTH-1:0]     out_b_data,
  output logic [CNT_WIDTH-1:0] a_count,
  output logic [CNT_WIDTH-1:0] b_count
);

  logic free_a;
  logic free_b;
  logic accept;
  logic load_a;
  logic load_b;

  // in_ready depends only on select, slot state and consumer ready, never on in_valid/in_data.
  always_comb begin
    in_ready = 1'b0;
    if (!Reset) begin
      in_ready = (in_sel == SEL_B) ? free_b : free_a;
    end
  end

  assign accept = in_valid && in_ready;
  assign load_a = accept && (in_sel == SEL_A);
  assign load_b = accept && (in_sel == SEL_B);

  demux_slot #(
    .Width    (WIDTH),
    .CntWidth (CNT_WIDTH)
  ) u_slot_a (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (load_a),
    .load_data_i (in_data),
    .ready_i     (out_a_ready),
    .free_o      (free_a),
    .valid_o     (out_a_valid),
    .data_o      (out_a_data),
    .count_o     (a_count)
  );

  demux_slot #(
    .Width    (WIDTH),
    .CntWidth (CNT_WIDTH)
  ) u_slot_b (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (load_b),
    .load_data_i (in_data),
    .ready_i     (out_b_ready),
    .free_o      (free_b),
    .valid_o     (out_b_valid),
    .data_o      (out_b_data),
    .count_o     (b_count)
  );

endmodule
